pc_predict: RTL and testbench

Registered fetch-PC unit for the pipelined Y86-64 core, the successor to the single-cycle SEQ next-PC selector. Each cycle it predicts the next PC from the instruction being fetched: valC for call/jXX, a return-address-stack (RAS) top for ret, and valP otherwise. It then applies late corrections from the memory stage (jXX mispredict) and the writeback stage (ret target mismatch), and holds the result in a PC register that drives fetch. Address width and RAS depth are parameters. RAS_DEPTH=0 gives a plain predict-taken PC with no return prediction.

---
 rtl/y86_pkg.sv | 18 +
 rtl/pc_predict_if.sv | 47 ++++
 rtl/ras_stack.sv | 74 +++++++
 rtl/pc_predict.sv | 109 ++++++++++
 tb/tb_pc_predict.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: definitions shared by the pipelined Y86-64 fetch logic.
//   - icode constants for the control-flow instructions
//   - default address width
//   - ras_cnt_w(): width of a RAS occupancy count (at least 1 bit so that a
//     stack-less build still has a legal port)
package y86_pkg;

  localparam int DEFAULT_ADDR_W = 64;

  localparam logic [3:0] JXX  = 4'h7;
  localparam logic [3:0] CALL = 4'h8;
  localparam logic [3:0] RET  = 4'h9;

  function automatic int ras_cnt_w(input int depth);
    return (depth > 0) ? $clog2(depth + 1) : 1;
  endfunction

endpackage

// File: rtl/pc_predict_if.sv
// pc_predict_if: bundle between the pipeline and the fetch-PC unit.
//   Pipeline -> unit : stall_f, f_icode/f_valc/f_valp (fetch stage),
//                      m_icode/m_cnd/m_vala (memory stage jXX resolution),
//                      w_icode/w_valm/w_pred (writeback stage ret check)
//   Unit -> pipeline : pc, pred_pc, ras_hit, redirect, ras_count
// master = pipeline side, slave = pc_predict.
interface pc_predict_if
  import y86_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int RAS_DEPTH = 8
) ();

  localparam int CNT_W = ras_cnt_w(RAS_DEPTH);

  logic              stall_f;
  logic [3:0]        f_icode;
  logic [ADDR_W-1:0] f_valc;
  logic [ADDR_W-1:0] f_valp;
  logic [3:0]        m_icode;
  logic              m_cnd;
  logic [ADDR_W-1:0] m_vala;
  logic [3:0]        w_icode;
  logic [ADDR_W-1:0] w_valm;
  logic [ADDR_W-1:0] w_pred;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pred_pc;
  logic              ras_hit;
  logic              redirect;
  logic [CNT_W-1:0]  ras_count;

  modport master (
    output stall_f, f_icode, f_valc, f_valp,
    output m_icode, m_cnd, m_vala,
    output w_icode, w_valm, w_pred,
    input  pc, pred_pc, ras_hit, redirect, ras_count
  );

  modport slave (
    input  stall_f, f_icode, f_valc, f_valp,
    input  m_icode, m_cnd, m_vala,
    input  w_icode, w_valm, w_pred,
    output pc, pred_pc, ras_hit, redirect, ras_count
  );

endinterface

// File: rtl/ras_stack.sv
// ras_stack: return-address stack with a circular pointer.
//   clk, rst : clock, synchronous active-high reset (empties the stack)
//   push     : write din on top; when full the oldest entry is overwritten
//   pop      : drop the top entry; ignored when empty
//   flush    : empty the stack (count=0, pointer=0); dominates push/pop
//   din      : address to push
//   top      : most recently pushed valid entry (meaningless when count=0)
//   count    : valid entries, saturating at DEPTH
// push and pop are never requested together; push wins if they are.
module ras_stack #(
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          din,
  output logic [ADDR_W-1:0]          top,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;  // next free slot
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  ptr_inc, ptr_dec;

  // Wrap explicitly so non-power-of-two depths behave as a true ring.
  always_comb begin
    ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    ptr_dec = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - 1'b1;
  end

  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (flush) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (push) begin
      mem_d[ptr_q] = din;
      ptr_d        = ptr_inc;
      if (count_q != CNT_W'(DEPTH)) count_d = count_q + 1'b1;
    end else if (pop && (count_q != '0)) begin
      ptr_d   = ptr_dec;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Entry contents need no reset: count gates every use of them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign top   = mem_q[ptr_dec];
  assign count = count_q;

endmodule

// File: rtl/pc_predict.sv
// pc_predict: registered fetch-PC unit.
//   clk, rst : clock, synchronous active-high reset (pc=RESET_PC, RAS empty)
//   bus      : pc_predict_if.slave
//     pred_pc  - combinational next-PC guess (valC for call/jXX, RAS top for
//                ret, valP otherwise)
//     ras_hit  - a ret is fetched and pred_pc came from the RAS
//     redirect - a late correction (ret mismatch in W, jXX not taken in M)
//                replaces the prediction this cycle
//     pc       - fetch address register
//     ras_count- RAS occupancy
// A correction loads pc even while stall_f holds fetch, and flushes the RAS.
module pc_predict
  import y86_pkg::*;
#(
  parameter int                ADDR_W    = DEFAULT_ADDR_W,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic       clk,
  input  logic       rst,
  pc_predict_if.slave bus
);

  localparam int CNT_W = ras_cnt_w(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pred_pc;
  logic              ras_hit;
  logic [ADDR_W-1:0] corr_pc;
  logic              redirect;
  logic [ADDR_W-1:0] ras_top;
  logic [CNT_W-1:0]  ras_count;

  // Prediction from the instruction being fetched.
  always_comb begin
    pred_pc = bus.f_valp;
    ras_hit = 1'b0;
    case (bus.f_icode)
      CALL, JXX: pred_pc = bus.f_valc;
      RET: begin
        if (ras_count != '0) begin
          pred_pc = ras_top;
          ras_hit = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // The ret in writeback is older than the jXX in memory, so it wins.
  always_comb begin
    corr_pc  = bus.m_vala;
    redirect = 1'b0;
    if ((bus.w_icode == RET) && (bus.w_valm != bus.w_pred)) begin
      corr_pc  = bus.w_valm;
      redirect = 1'b1;
    end else if ((bus.m_icode == JXX) && !bus.m_cnd) begin
      corr_pc  = bus.m_vala;
      redirect = 1'b1;
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect)          pc_d = corr_pc;
    else if (!bus.stall_f) pc_d = pred_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  generate
    if (RAS_DEPTH > 0) begin : g_ras
      logic ras_upd;
      logic ras_push;
      logic ras_pop;

      assign ras_upd  = !redirect && !bus.stall_f;
      assign ras_push = ras_upd && (bus.f_icode == CALL);
      assign ras_pop  = ras_upd && (bus.f_icode == RET);

      ras_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
      ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .flush (redirect),
        .din   (bus.f_valp),
        .top   (ras_top),
        .count (ras_count)
      );
    end else begin : g_no_ras
      assign ras_top   = '0;
      assign ras_count = '0;
    end
  endgenerate

  assign bus.pc        = pc_q;
  assign bus.pred_pc   = pred_pc;
  assign bus.ras_hit   = ras_hit;
  assign bus.redirect  = redirect;
  assign bus.ras_count = ras_count;

endmodule

// File: tb/tb_pc_predict.sv
// tb_pc_predict: directed and randomized checks of pc_predict with an 8-entry
// RAS (dut8) and without a RAS (dut0). The reference model keeps the return
// stack as a queue of addresses and the expected pc as a plain variable.
module tb_pc_predict;
  import y86_pkg::*;

  localparam int             AW     = 64;
  localparam int             DEPTH  = 8;
  localparam logic [AW-1:0]  RST_PC = 64'h100;
  localparam logic [3:0]     NOP    = 4'h1;
  localparam logic [3:0]     OPQ    = 4'h6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_predict_if #(.ADDR_W(AW), .RAS_DEPTH(DEPTH)) bus8 ();
  pc_predict_if #(.ADDR_W(AW), .RAS_DEPTH(0))     bus0 ();

  pc_predict #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut8 (
    .clk (clk), .rst (rst), .bus (bus8)
  );
  pc_predict #(.ADDR_W(AW), .RAS_DEPTH(0), .RESET_PC(RST_PC)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state for dut8.
  logic [AW-1:0] ras_q[$];
  logic [AW-1:0] exp_pc;
  logic [AW-1:0] exp_pred;
  logic          exp_hit;
  logic          exp_redir;

  function automatic logic w_mismatch();
    return (bus8.w_icode == RET) && (bus8.w_valm != bus8.w_pred);
  endfunction

  function automatic logic m_mispredict();
    return (bus8.m_icode == JXX) && !bus8.m_cnd;
  endfunction

  function void model_comb();
    exp_hit  = 1'b0;
    exp_pred = bus8.f_valp;
    if (bus8.f_icode == CALL || bus8.f_icode == JXX) begin
      exp_pred = bus8.f_valc;
    end else if (bus8.f_icode == RET && ras_q.size() > 0) begin
      exp_pred = ras_q[$];
      exp_hit  = 1'b1;
    end
    exp_redir = w_mismatch() || m_mispredict();
  endfunction

  // Advance the model with the inputs present now, then clock the DUTs.
  task automatic tick();
    model_comb();
    if (rst) begin
      exp_pc = RST_PC;
      ras_q.delete();
    end else if (exp_redir) begin
      exp_pc = w_mismatch() ? bus8.w_valm : bus8.m_vala;
      ras_q.delete();
    end else if (!bus8.stall_f) begin
      exp_pc = exp_pred;
      if (bus8.f_icode == CALL) begin
        ras_q.push_back(bus8.f_valp);
        if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
      end else if (bus8.f_icode == RET && ras_q.size() > 0) begin
        void'(ras_q.pop_back());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus8.stall_f = 1'b0; bus8.f_icode = NOP; bus8.f_valc = '0; bus8.f_valp = '0;
    bus8.m_icode = NOP;  bus8.m_cnd = 1'b1;  bus8.m_vala = '0;
    bus8.w_icode = NOP;  bus8.w_valm = '0;   bus8.w_pred = '0;
    bus0.stall_f = 1'b0; bus0.f_icode = NOP; bus0.f_valc = '0; bus0.f_valp = '0;
    bus0.m_icode = NOP;  bus0.m_cnd = 1'b1;  bus0.m_vala = '0;
    bus0.w_icode = NOP;  bus0.w_valm = '0;   bus0.w_pred = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    bus8.f_icode = CALL; bus8.f_valc = 64'h777;
    #1;
    n_cmp++;
    if (bus8.pred_pc !== 64'h777) begin
      n_fail++; $display("FAIL reset_comb_pred: got %h want %h", bus8.pred_pc, 64'h777);
    end
    tick();
    tick();
    rst = 1'b0;
    idle();
    n_cmp++;
    if (bus8.pc !== RST_PC) begin
      n_fail++; $display("FAIL reset_pc: got %h want %h", bus8.pc, RST_PC);
    end
    n_cmp++;
    if (bus8.ras_count !== 4'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", bus8.ras_count);
    end
    n_cmp++;
    if (bus0.pc !== RST_PC) begin
      n_fail++; $display("FAIL reset_pc_noras: got %h want %h", bus0.pc, RST_PC);
    end
  endtask

  task automatic test_basic();
    bus8.f_icode = OPQ; bus8.f_valp = 64'h102;
    #1;
    n_cmp++;
    if (bus8.pred_pc !== 64'h102 || bus8.ras_hit !== 1'b0) begin
      n_fail++; $display("FAIL basic_pred: got %h/%b want 102/0", bus8.pred_pc, bus8.ras_hit);
    end
    tick();
    n_cmp++;
    if (bus8.pc !== 64'h102 || bus8.ras_count !== 4'd0) begin
      n_fail++; $display("FAIL basic_pc: got %h/%0d want 102/0", bus8.pc, bus8.ras_count);
    end
  endtask

  task automatic test_call_ret();
    bus8.f_icode = CALL; bus8.f_valc = 64'h400; bus8.f_valp = 64'h10A;
    tick();
    n_cmp++;
    if (bus8.pc !== 64'h400 || bus8.ras_count !== 4'd1) begin
      n_fail++; $display("FAIL call_pc: got %h/%0d want 400/1", bus8.pc, bus8.ras_count);
    end
    bus8.f_icode = RET; bus8.f_valc = 64'h0; bus8.f_valp = 64'h401;
    #1;
    n_cmp++;
    if (bus8.pred_pc !== 64'h10A || bus8.ras_hit !== 1'b1) begin
      n_fail++; $display("FAIL ret_pred: got %h/%b want 10a/1", bus8.pred_pc, bus8.ras_hit);
    end
    tick();
    n_cmp++;
    if (bus8.pc !== 64'h10A || bus8.ras_count !== 4'd0) begin
      n_fail++; $display("FAIL ret_pc: got %h/%0d want 10a/0", bus8.pc, bus8.ras_count);
    end
  endtask

  task automatic test_flush_stall();
    bus8.f_icode = CALL; bus8.f_valc = 64'h800; bus8.f_valp = 64'h123;
    tick();
    bus8.stall_f = 1'b1; bus8.f_valc = 64'h900; bus8.f_valp = 64'h809;
    bus8.m_icode = JXX;  bus8.m_cnd = 1'b0;    bus8.m_vala = 64'h220;
    #1;
    n_cmp++;
    if (bus8.redirect !== 1'b1) begin
      n_fail++; $display("FAIL flush_redirect: got %b want 1", bus8.redirect);
    end
    tick();
    n_cmp++;
    if (bus8.pc !== 64'h220 || bus8.ras_count !== 4'd0) begin
      n_fail++; $display("FAIL flush_pc: got %h/%0d want 220/0", bus8.pc, bus8.ras_count);
    end
    idle();
  endtask

  task automatic test_saturate();
    logic [AW-1:0] want;
    for (int i = 1; i <= 9; i++) begin
      bus8.f_icode = CALL; bus8.f_valc = 64'h1000 + i; bus8.f_valp = 64'h10 * i;
      tick();
      n_cmp++;
      if (bus8.pc !== 64'h1000 + i || bus8.ras_count !== 4'((i > 8) ? 8 : i)) begin
        n_fail++;
        $display("FAIL sat_push%0d: got %h/%0d want %h/%0d", i, bus8.pc, bus8.ras_count,
                 64'h1000 + i, (i > 8) ? 8 : i);
      end
    end
    for (int i = 1; i <= 9; i++) begin
      bus8.f_icode = RET; bus8.f_valc = '0; bus8.f_valp = 64'h2000 + i;
      want = (i <= 8) ? 64'h10 * (10 - i) : 64'h2000 + i;
      #1;
      n_cmp++;
      if (bus8.pred_pc !== want || bus8.ras_hit !== (i <= 8)) begin
        n_fail++;
        $display("FAIL sat_pop%0d: got %h/%b want %h/%b", i, bus8.pred_pc, bus8.ras_hit,
                 want, (i <= 8));
      end
      tick();
      n_cmp++;
      if (bus8.pc !== want || bus8.ras_count !== 4'((i <= 8) ? 8 - i : 0)) begin
        n_fail++;
        $display("FAIL sat_popcnt%0d: got %h/%0d want %h/%0d", i, bus8.pc, bus8.ras_count,
                 want, (i <= 8) ? 8 - i : 0);
      end
    end
    idle();
  endtask

  task automatic test_priority();
    bus8.f_icode = OPQ;  bus8.f_valp = 64'h50;
    bus8.w_icode = RET;  bus8.w_valm = 64'h500; bus8.w_pred = 64'h600;
    bus8.m_icode = JXX;  bus8.m_cnd = 1'b0;     bus8.m_vala = 64'h300;
    #1;
    n_cmp++;
    if (bus8.redirect !== 1'b1) begin
      n_fail++; $display("FAIL prio_redirect: got %b want 1", bus8.redirect);
    end
    tick();
    n_cmp++;
    if (bus8.pc !== 64'h500) begin
      n_fail++; $display("FAIL prio_w_wins: got %h want 500", bus8.pc);
    end
    bus8.w_pred = 64'h500;
    tick();
    n_cmp++;
    if (bus8.pc !== 64'h300) begin
      n_fail++; $display("FAIL prio_m_only: got %h want 300", bus8.pc);
    end
    bus8.m_cnd = 1'b1;
    #1;
    n_cmp++;
    if (bus8.redirect !== 1'b0) begin
      n_fail++; $display("FAIL prio_none: got %b want 0", bus8.redirect);
    end
    idle();
  endtask

  task automatic test_stall();
    bus8.f_icode = CALL; bus8.f_valc = 64'hA00; bus8.f_valp = 64'h0F0;
    tick();
    bus8.stall_f = 1'b1; bus8.f_valc = 64'hB00; bus8.f_valp = 64'hA09;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (bus8.pc !== 64'hA00 || bus8.ras_count !== 4'd1 || bus8.redirect !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got %h/%0d/%b want a00/1/0", i, bus8.pc,
                 bus8.ras_count, bus8.redirect);
      end
    end
    idle();
  endtask

  task automatic test_no_ras();
    bus0.f_icode = CALL; bus0.f_valc = 64'h40; bus0.f_valp = 64'h33;
    tick();
    n_cmp++;
    if (bus0.pc !== 64'h40 || bus0.ras_count !== 1'b0) begin
      n_fail++; $display("FAIL noras_call: got %h/%0d want 40/0", bus0.pc, bus0.ras_count);
    end
    bus0.f_icode = RET; bus0.f_valc = '0; bus0.f_valp = 64'h41;
    #1;
    n_cmp++;
    if (bus0.pred_pc !== 64'h41 || bus0.ras_hit !== 1'b0) begin
      n_fail++; $display("FAIL noras_ret: got %h/%b want 41/0", bus0.pred_pc, bus0.ras_hit);
    end
    tick();
    n_cmp++;
    if (bus0.pc !== 64'h41) begin
      n_fail++; $display("FAIL noras_ret_pc: got %h want 41", bus0.pc);
    end
    idle();
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 9);
      bus8.f_icode = (r < 4) ? CALL : (r < 7) ? RET : (r < 8) ? JXX : OPQ;
      bus8.f_valc  = {$urandom, $urandom};
      bus8.f_valp  = {$urandom, $urandom};
      bus8.stall_f = ($urandom_range(0, 7) == 0);
      bus8.m_icode = ($urandom_range(0, 11) == 0) ? JXX : OPQ;
      bus8.m_cnd   = $urandom_range(0, 1);
      bus8.m_vala  = {$urandom, $urandom};
      bus8.w_icode = ($urandom_range(0, 11) == 0) ? RET : OPQ;
      bus8.w_pred  = {$urandom, $urandom};
      bus8.w_valm  = $urandom_range(0, 1) ? bus8.w_pred : {$urandom, $urandom};
      rst          = ($urandom_range(0, 63) == 0);
      #1;
      model_comb();
      n_cmp++;
      if (bus8.pred_pc !== exp_pred || bus8.ras_hit !== exp_hit ||
          bus8.redirect !== exp_redir) begin
        n_fail++;
        $display("FAIL rand_comb%0d: got %h/%b/%b want %h/%b/%b", c, bus8.pred_pc,
                 bus8.ras_hit, bus8.redirect, exp_pred, exp_hit, exp_redir);
      end
      tick();
      n_cmp++;
      if (bus8.pc !== exp_pc || bus8.ras_count !== 4'(ras_q.size())) begin
        n_fail++;
        $display("FAIL rand_state%0d: got %h/%0d want %h/%0d", c, bus8.pc,
                 bus8.ras_count, exp_pc, ras_q.size());
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    exp_pc = RST_PC;
    test_reset();
    test_basic();
    test_call_ret();
    test_flush_stall();
    test_saturate();
    test_priority();
    test_stall();
    test_no_ras();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
